// File: rtl/vga_layer_arbiter.sv
// Four-layer VGA pixel arbiter: fixed-priority compositing, frame-shadowed config,
// and per-frame pairwise layer-overlap flags.
module vga_layer_arbiter #(
    parameter int unsigned          RGB_W        = 12,
    parameter logic [3:0]           DEFAULT_MASK = 4'hF,
    parameter logic [RGB_W-1:0]     DEFAULT_BG   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_tick,
    input  logic                 video_on,
    input  logic                 frame_start,
    input  logic [3:0]           req,
    input  logic [4*RGB_W-1:0]   layer_rgb,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [RGB_W-1:0]     cfg_wdata,
    output logic [RGB_W-1:0]     rgb,
    output logic [3:0]           grant,
    output logic [5:0]           coll_flags,
    output logic                 coll_valid
);

    logic [3:0]         pend_mask, act_mask;
    logic [RGB_W-1:0]   pend_bg, act_bg;

    logic [3:0]         s1_m;
    logic [4*RGB_W-1:0] s1_rgb;
    logic               s1_vid;

    logic [5:0]         coll_acc;

    logic [3:0]         cap_mask;
    logic [3:0]         m;
    logic [5:0]         hits;
    logic [RGB_W-1:0]   nxt_rgb;
    logic [3:0]         nxt_grant;
    logic               found;

    // Capture on a frame_start edge already sees the mask being committed there.
    always_comb begin
        cap_mask = frame_start ? pend_mask : act_mask;
        m        = req & cap_mask;
        hits     = '0;
        if (p_tick && video_on)
            hits = {m[2] & m[3], m[1] & m[3], m[1] & m[2],
                    m[0] & m[3], m[0] & m[2], m[0] & m[1]};
    end

    always_comb begin
        nxt_rgb   = '0;
        nxt_grant = '0;
        found     = 1'b0;
        if (s1_vid) begin
            if (s1_m == '0) begin
                nxt_rgb = act_bg;
            end else begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (!found && s1_m[i]) begin
                        found        = 1'b1;
                        nxt_grant[i] = 1'b1;
                        nxt_rgb      = s1_rgb[i*RGB_W +: RGB_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_mask <= DEFAULT_MASK;
            act_mask  <= DEFAULT_MASK;
            pend_bg   <= DEFAULT_BG;
            act_bg    <= DEFAULT_BG;
        end else begin
            if (frame_start) begin
                act_mask <= pend_mask;
                act_bg   <= pend_bg;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    pend_mask <= cfg_wdata[3:0];
                    2'd1:    pend_bg   <= cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_m   <= '0;
            s1_rgb <= '0;
            s1_vid <= 1'b0;
            rgb    <= '0;
            grant  <= '0;
        end else if (p_tick) begin
            s1_m   <= m;
            s1_rgb <= layer_rgb;
            s1_vid <= video_on;
            rgb    <= nxt_rgb;
            grant  <= nxt_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coll_acc   <= '0;
            coll_flags <= '0;
            coll_valid <= 1'b0;
        end else if (frame_start) begin
            coll_flags <= coll_acc | hits;
            coll_acc   <= '0;
            coll_valid <= 1'b1;
        end else begin
            coll_acc   <= coll_acc | hits;
            coll_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Self-checking bench for vga_layer_arbiter: stimulus table plus a scoreboard queue
// holding each ticked pixel's expected result until it leaves the 2-stage pipeline.
module tb_vga_layer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick, video_on, frame_start;
    logic [3:0]  req;
    logic [47:0] layer_rgb;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic [11:0] rgb;
    logic [3:0]  grant;
    logic [5:0]  coll_flags;
    logic        coll_valid;

    vga_layer_arbiter #(.RGB_W(12), .DEFAULT_MASK(4'hF), .DEFAULT_BG(12'h000)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .frame_start(frame_start), .req(req), .layer_rgb(layer_rgb),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rgb(rgb), .grant(grant), .coll_flags(coll_flags), .coll_valid(coll_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        vid;
        logic [11:0] rgb;
        logic [3:0]  grant;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        logic [3:0]  grant;
        logic        bg_sel;
    } exp_t;

    localparam logic [47:0] COLS = {12'h888, 12'h0F0, 12'hF00, 12'h123};

    vec_t  tab[8];
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    ticks  = 0;

    logic [3:0]  pend_mask, act_mask;
    logic [11:0] pend_bg, act_bg;
    logic [5:0]  acc;
    logic [11:0] last_rgb;
    logic [3:0]  last_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] pairs(input logic [3:0] v);
        logic [5:0] p;
        p[0] = v[0] & v[1];
        p[1] = v[0] & v[2];
        p[2] = v[0] & v[3];
        p[3] = v[1] & v[2];
        p[4] = v[1] & v[3];
        p[5] = v[2] & v[3];
        return p;
    endfunction

    function automatic exp_t model(input logic [3:0] v, input logic vid);
        exp_t e;
        e.rgb = 12'h000; e.grant = 4'b0000; e.bg_sel = 1'b0;
        if (!vid)       ;
        else if (v[0])  begin e.rgb = COLS[11:0];  e.grant = 4'b0001; end
        else if (v[1])  begin e.rgb = COLS[23:12]; e.grant = 4'b0010; end
        else if (v[2])  begin e.rgb = COLS[35:24]; e.grant = 4'b0100; end
        else if (v[3])  begin e.rgb = COLS[47:36]; e.grant = 4'b1000; end
        else            e.bg_sel = 1'b1;
        return e;
    endfunction

    task automatic step(input logic pt, input logic vid, input logic [3:0] rq,
                        input logic fs, input logic we, input logic [1:0] ad,
                        input logic [11:0] wd, input logic tv,
                        input logic [11:0] trgb, input logic [3:0] tgr);
        exp_t        e;
        logic [3:0]  mm;
        logic [5:0]  h;
        logic [5:0]  exp_coll;
        logic [11:0] bg_pre, er;
        p_tick = pt; video_on = vid; req = rq; frame_start = fs;
        cfg_we = we; cfg_addr = ad; cfg_wdata = wd; layer_rgb = COLS;
        mm = rq & (fs ? pend_mask : act_mask);
        if (pt) begin
            if (tv) begin e.rgb = trgb; e.grant = tgr; e.bg_sel = 1'b0; end
            else e = model(mm, vid);
            q.push_back(e);
        end
        h = (pt && vid) ? pairs(mm) : 6'b0;
        exp_coll = acc | h;
        acc = fs ? 6'b0 : exp_coll;
        bg_pre = act_bg;
        @(posedge clk);
        #1;
        if (pt) begin
            ticks++;
            if (ticks >= 2) begin
                if (q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    er = e.bg_sel ? bg_pre : e.rgb;
                    check("rgb", rgb, er);
                    check("grant", grant, e.grant);
                    last_rgb = er; last_grant = e.grant;
                end
            end
        end else if (ticks >= 2) begin
            check("hold_rgb", rgb, last_rgb);
            check("hold_grant", grant, last_grant);
        end
        check("coll_valid", coll_valid, fs);
        if (fs) check("coll_flags", coll_flags, exp_coll);
        if (fs) begin act_mask = pend_mask; act_bg = pend_bg; end
        if (we && ad == 2'd0) pend_mask = wd[3:0];
        if (we && ad == 2'd1) pend_bg = wd;
    endtask

    task automatic pix(input logic vid, input logic [3:0] rq);
        step(1'b1, vid, rq, 1'b0, 1'b0, 2'd0, 12'h0, 1'b0, 12'h0, 4'h0);
    endtask

    task automatic idle(input logic fs, input logic we, input logic [1:0] ad, input logic [11:0] wd);
        step(1'b0, 1'b0, 4'h0, fs, we, ad, wd, 1'b0, 12'h0, 4'h0);
    endtask

    initial begin
        tab[0] = '{4'b0110, 1'b1, 12'hF00, 4'b0010};
        tab[1] = '{4'b1000, 1'b1, 12'h888, 4'b1000};
        tab[2] = '{4'b1111, 1'b1, 12'h123, 4'b0001};
        tab[3] = '{4'b0100, 1'b1, 12'h0F0, 4'b0100};
        tab[4] = '{4'b0000, 1'b1, 12'h000, 4'b0000};
        tab[5] = '{4'b1111, 1'b0, 12'h000, 4'b0000};
        tab[6] = '{4'b1010, 1'b1, 12'hF00, 4'b0010};
        tab[7] = '{4'b1100, 1'b1, 12'h0F0, 4'b0100};

        pend_mask = 4'hF; act_mask = 4'hF; pend_bg = 12'h000; act_bg = 12'h000;
        acc = 6'b0; last_rgb = 12'h0; last_grant = 4'h0;
        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; frame_start = 1'b0;
        req = 4'h0; layer_rgb = COLS; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 12'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", rgb, 12'h000);
        check("reset_grant", grant, 4'h0);
        check("reset_coll_flags", coll_flags, 6'h0);
        check("reset_coll_valid", coll_valid, 1'b0);
        reset = 1'b1;

        repeat (4) pix(1'b1, 4'h0);

        for (int i = 0; i < 8; i++)
            step(1'b1, tab[i].vid, tab[i].req, 1'b0, 1'b0, 2'd0, 12'h0,
                 1'b1, tab[i].rgb, tab[i].grant);
        repeat (2) pix(1'b0, 4'hF);
        repeat (3) idle(1'b0, 1'b0, 2'd0, 12'h0);
        idle(1'b1, 1'b0, 2'd0, 12'h0);

        // Shadowed config: writes stay pending until the next frame_start.
        idle(1'b0, 1'b1, 2'd0, 12'h00E);
        idle(1'b0, 1'b1, 2'd1, 12'h00F);
        idle(1'b0, 1'b1, 2'd2, 12'hABC);
        idle(1'b0, 1'b1, 2'd3, 12'h321);
        repeat (3) pix(1'b1, 4'b0001);
        check("shadow_before_fs", rgb, 12'h123);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        repeat (3) pix(1'b1, 4'b0001);
        check("shadow_after_fs_rgb", rgb, 12'h00F);
        check("shadow_after_fs_grant", grant, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd1, 12'h0AB, 1'b0, 12'h0, 4'h0);
        repeat (3) pix(1'b1, 4'b0001);
        check("same_cycle_write_deferred", rgb, 12'h00F);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        repeat (3) pix(1'b1, 4'b0001);
        check("same_cycle_write_committed", rgb, 12'h0AB);
        idle(1'b0, 1'b1, 2'd0, 12'h00F);
        idle(1'b1, 1'b0, 2'd0, 12'h0);

        // Collisions over a frame, then a clean frame.
        pix(1'b1, 4'b0011);
        pix(1'b1, 4'b0101);
        repeat (2) pix(1'b0, 4'h0);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        check("coll_two_pairs", coll_flags, 6'b000011);
        pix(1'b1, 4'b0001);
        pix(1'b1, 4'b0100);
        repeat (2) pix(1'b0, 4'h0);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        check("coll_clean_frame", coll_flags, 6'b000000);

        // Back-to-back frame_start pulses, one carrying a same-cycle hit.
        pix(1'b1, 4'b1100);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        step(1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 2'd0, 12'h0, 1'b0, 12'h0, 4'h0);
        check("coll_b2b_same_cycle", coll_flags, 6'b000001);
        idle(1'b1, 1'b0, 2'd0, 12'h0);

        // Disabled layer 0 must not create collisions.
        idle(1'b0, 1'b1, 2'd0, 12'h00E);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        pix(1'b1, 4'b0011);
        pix(1'b1, 4'b0101);
        repeat (2) pix(1'b0, 4'h0);
        idle(1'b1, 1'b0, 2'd0, 12'h0);
        check("coll_disabled_layer", coll_flags, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_layer_arbiter.md
Name: vga_layer_arbiter

Overview:
Arbitrates the single VGA RGB output between four graphic layers: 0 = ball, 1 = left paddle, 2 = right paddle, 3 = score/overlay. It sits between the per-object pixel generators and the top-level rgb port, clocked by the same clk and enabled by the sync unit's pixel tick. Configuration writes are shadowed and committed only at frame boundaries, so there is no mid-frame tearing. The block also accumulates per-frame pairwise layer-overlap (collision) flags for the game logic.

Parameters:
RGB_W, 12, colour width per layer and for the output.
DEFAULT_MASK, 4'hF, reset value of the pending and active layer-enable masks.
DEFAULT_BG, 12'h000, reset value of the pending and active background colour.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
p_tick  in  1  pixel enable; the pipeline advances only when p_tick=1.
video_on  in  1  active-display flag from the sync unit, aligned with req.
frame_start  in  1  one-clk pulse at the start of each frame (first vsync-blank cycle).
req  in  4  per-layer "pixel hit" flags for the current pixel.
layer_rgb  in  4*RGB_W  packed layer colours; layer i occupies bits [i*RGB_W +: RGB_W].
cfg_we  in  1  configuration write strobe.
cfg_addr  in  2  0 = enable mask (wdata[3:0]), 1 = background colour; 2 and 3 are ignored.
cfg_wdata  in  RGB_W  write data.
rgb  out  RGB_W  arbitrated pixel colour.
grant  out  4  one-hot winning layer for rgb; 0 when background or blank.
coll_flags  out  6  previous frame's overlap flags.
coll_valid  out  1  one-clk pulse when coll_flags updates.

Behaviour:
- Reset (reset=0, async):
  - rgb=0, grant=0, coll_flags=0, coll_valid=0.
  - All pipeline registers = 0; collision accumulator = 0.
  - Pending and active mask = DEFAULT_MASK; pending and active bg = DEFAULT_BG.
  - Reset mid-frame discards all in-flight pixels.
- Configuration:
  - cfg_we=1 writes the pending register selected by cfg_addr on that clk edge, regardless of p_tick.
  - On a frame_start clk, active <= pending, using the pending value before any same-cycle write. A write coinciding with frame_start is committed at the next frame_start.
- Pipeline (2 p_tick stages; all registers hold when p_tick=0):
  - S1 captures:
    - m = req & active_mask
    - layer_rgb
    - video_on
  - S2 computes:
    - If S1.video_on=0: rgb=0, grant=0.
    - Else if m=0: rgb=active_bg, grant=0.
    - Else: the lowest-index set bit of m wins (fixed priority, layer 0 highest); rgb = that layer's colour, grant = its one-hot.
  - Latency: a pixel presented with p_tick appears on rgb after exactly 2 p_tick-qualified edges. The top level delays hsync/vsync by 2 pixel ticks to match.
  - An active_mask change at frame_start affects pixels captured into S1 from that edge onward. Pixels already in S2 are unaffected.
- Collision accumulation:
  - On each p_tick edge with video_on=1, the accumulator ORs in the pair bits from m (masked req):
    - bit0 = (0,1), bit1 = (0,2), bit2 = (0,3)
    - bit3 = (1,2), bit4 = (1,3), bit5 = (2,3)
  - On a frame_start clk: coll_flags <= accumulator | this cycle's hits (if p_tick and video_on); accumulator <= 0; coll_valid=1 for exactly that one clk.
  - A disabled layer never contributes to collisions.
- Boundary cases:
  - frame_start coinciding with p_tick: S1/S2 advance normally.
  - Back-to-back frame_start pulses: each commits the config and pulses coll_valid. The second reports only hits made between the two pulses.
  - cfg_addr 2 or 3: the write is ignored and no state changes.

Test Plan:
- Reset: hold reset=0, then release -> rgb=0, grant=0, coll_flags=0. With video_on=1, req=0 and p_tick every clk, rgb=12'h000 from the 2nd tick.
- Priority: req=4'b0110, layer1=12'hF00, layer2=12'h0F0, video_on=1 -> rgb=12'hF00, grant=4'b0010 two ticks later. With req=4'b1000 -> rgb=layer3 colour, grant=4'b1000.
- Blanking and hold: video_on=0 with req=4'hF -> rgb=0, grant=0. With p_tick=0 for 3 clks, rgb and grant remain unchanged.
- Shadowed config, part 1: mid-frame write addr0=4'b1110 and addr1=12'h00F; req=4'b0001 -> rgb stays the layer0 colour until frame_start.
- Shadowed config, part 2: after frame_start the same stimulus gives rgb=12'h00F and grant=0. A write in the same cycle as frame_start takes effect only at the following frame_start.
- Collision: during a frame, one pixel with req=4'b0011 and one with req=4'b0101 -> at the next frame_start, coll_flags=6'b000011 and coll_valid is high for 1 clk. The following frame with no overlap -> coll_flags=0.
